sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO: the same-clock counterpart of the team's dual-clock FIFO, generalised with a fill count, programmable almost-full/almost-empty thresholds, a selectable read mode, and sticky overflow/underflow error flags. Used wherever producer and consumer share one clock, e.g. the buffering stage ahead of the dual-clock FIFO. Pointer logic is binary with an extra wrap bit; no Gray coding or synchronisers are needed.

## Interface
- DSIZE, 8: data width in bits.
- ASIZE, 4: address width; depth = 1<<ASIZE entries.
- AFULL_TH, (1<<ASIZE)-2: almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH.
- FWFT, 1: 1 = first-word-fall-through; 0 = registered read, one-cycle latency.

- clk  in  1  single clock; all logic is on posedge.
- rst  in  1  synchronous, active-high reset.
- wdata  in  DSIZE  write data.
- write  in  1  write request.
- full  out  1  no free entry.
- almost_full  out  1  count >= AFULL_TH.
- read  in  1  read (pop) request.
- rdata  out  DSIZE  read data (see Operation).
- empty  out  1  no valid entry.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ASIZE+1  current occupancy, 0..1<<ASIZE.
- err_clr  in  1  clears the sticky error flags.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- Pointers wptr and rptr are ASIZE+1 bits. Memory index is the low ASIZE bits. The MSB toggles on each wrap.
- full when the MSBs differ and the low bits are equal. empty when the pointers are equal. count = wptr - rptr, modulo 2^(ASIZE+1).
- rd_ok = read & ~empty.
- wr_ok = write & (~full | rd_ok). A write while full is accepted only if a read is accepted in the same cycle.
- On wr_ok: mem[wptr] <= wdata and wptr increments. On rd_ok: rptr increments.
- If wr_ok and rd_ok are both true, count is unchanged.
- FWFT=1: rdata = mem[rptr] (combinational from the RAM, registered address). It is valid whenever empty=0, and read acts as the pop acknowledge.
- FWFT=0: rdata is a register loaded with mem[rptr] on rd_ok. It holds its value otherwise.
- overflow sets on write & ~wr_ok. underflow sets on read & empty.
- Both error flags stay set until err_clr or rst. If err_clr and a new error occur in the same cycle, the flag stays set.
- An empty FIFO never accepts a read in the same cycle as a write. Read-through of a just-written word is not supported.

## Timing
- Reset values: wptr=rptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (for AFULL_TH>0), overflow=underflow=0, rdata=0.
- Reset mid-operation discards all contents. Memory contents are not cleared.
- Every flag and count is a function of the registered pointers, so each changes only on the clk edge after the causing handshake.
- Write-to-visible latency: a word written in cycle N gives empty=0 and is readable in cycle N+1.
- FWFT=1: rdata is valid in cycle N+1. FWFT=0: rdata is valid in the cycle after the rd_ok that requested it.
- Full-to-free: a read in cycle N gives full=0 in cycle N+1. The simultaneous read+write case above is the only zero-bubble path while full.
- Pointer wrap is natural modulo 2^(ASIZE+1). There is no special case at the boundary.
- Parameter legality (checked at elaboration): 0 <= AEMPTY_TH < AFULL_TH <= 1<<ASIZE, and ASIZE >= 1.

## Structure
- The shared package fifo_pkg holds:
  - the depth derivation (1<<ASIZE);
  - the pointer-compare helpers for full and empty;
  - the threshold-legality check.
- The dual-clock FIFO adopts the same package.
- Sub-module fifo_ram: DSIZE x (1<<ASIZE) memory with one write port and one asynchronous read port. The write port is enabled by wr_ok. sync_fifo instantiates it and adds the optional output register for FWFT=0.
- Everything else (pointers, count, flags, error logic) lives in sync_fifo.

## Test plan
All scenarios use DSIZE=8, ASIZE=4, AFULL_TH=14, AEMPTY_TH=2.
- Reset, then idle: empty=1, almost_empty=1, count=0, full=0, overflow=underflow=0.
- Write 0x00..0x0F on 16 consecutive cycles. Expect:
  - almost_empty drops when count=3;
  - almost_full rises when count=14;
  - full=1 and count=16 after the last write.
  - A 17th write (0xAA) sets overflow and is not stored.
- From full, drain 16 words.
  - FWFT=1: data is 0x00..0x0F in order with no gaps.
  - FWFT=0: each word appears one cycle after its read.
  - Empty=1 afterwards. A further read sets underflow.
  - err_clr clears both error flags.
- Full FIFO with simultaneous write 0x55 and read: the write is accepted, count stays 16, no overflow. 0x55 emerges after the 15 older words.
- Wrap-around: stream 40 words with random read/write gaps. Check order, count and flags against a reference queue; pointers wrap twice.
- Assert rst while count=9: the next cycle shows count=0 and empty=1. Writing 0x77 then reading returns 0x77.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth derivation, pointer compares, threshold legality.
// Used by both the single-clock and the dual-clock FIFO.
package fifo_pkg;

    function automatic int depth(input int asize);
        return 1 << asize;
    endfunction

    function automatic logic [31:0] ptr_mask(input int asize);
        return (32'd1 << (asize + 1)) - 32'd1;
    endfunction

    // Pointers carry one extra wrap bit above the memory index.
    function automatic logic ptr_full(
        input logic [31:0] w,
        input logic [31:0] r,
        input int          asize
    );
        return ((w ^ r) & ptr_mask(asize)) == (32'd1 << asize);
    endfunction

    function automatic logic ptr_empty(
        input logic [31:0] w,
        input logic [31:0] r,
        input int          asize
    );
        return ((w ^ r) & ptr_mask(asize)) == 32'd0;
    endfunction

    function automatic bit th_legal(
        input int asize,
        input int aempty,
        input int afull
    );
        return (asize >= 1) && (aempty >= 0) && (aempty < afull)
            && (afull <= (1 << asize));
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem [depth(ASIZE)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count, almost flags, sticky error flags
// and a selectable first-word-fall-through or registered read port.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             write,
    output logic             full,
    output logic             almost_full,
    input  logic             read,
    output logic [DSIZE-1:0] rdata,
    output logic             empty,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [ASIZE:0] AF  = (ASIZE + 1)'(AFULL_TH);
    localparam logic [ASIZE:0] AE  = (ASIZE + 1)'(AEMPTY_TH);
    localparam logic [ASIZE:0] INC = {{ASIZE{1'b0}}, 1'b1};

    if (!th_legal(ASIZE, AEMPTY_TH, AFULL_TH)) begin : g_bad_param
        $error("sync_fifo: illegal ASIZE/threshold parameters");
    end

    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic             rd_ok;
    logic             wr_ok;
    logic [DSIZE-1:0] ram_rdata;

    assign full         = ptr_full(32'(wptr), 32'(rptr), ASIZE);
    assign empty        = ptr_empty(32'(wptr), 32'(rptr), ASIZE);
    assign count        = wptr - rptr;
    assign almost_full  = count >= AF;
    assign almost_empty = count <= AE;

    // A full FIFO still takes a write when a pop frees a slot this cycle.
    assign rd_ok = read & ~empty;
    assign wr_ok = write & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + INC;
            end
            if (rd_ok) begin
                rptr <= rptr + INC;
            end
            overflow  <= (overflow & ~err_clr) | (write & ~wr_ok);
            underflow <= (underflow & ~err_clr) | (read & empty);
        end
    end

    fifo_ram #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) u_ram (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(wptr[ASIZE-1:0]),
        .wdata(wdata),
        .raddr(rptr[ASIZE-1:0]),
        .rdata(ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign rdata = ram_rdata;
    end else begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata <= '0;
            end else if (rd_ok) begin
                rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised bench for sync_fifo, FWFT and registered-read instances
// driven in lockstep and checked against a queue model.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wdata;
    logic       write;
    logic       read;
    logic       err_clr;

    logic       full1, afull1, empty1, aempty1, ovf1, unf1;
    logic [7:0] rdata1;
    logic [4:0] count1;
    logic       full0, afull0, empty0, aempty0, ovf0, unf0;
    logic [7:0] rdata0;
    logic [4:0] count0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    logic       ovf_m;
    logic       unf_m;
    logic [7:0] rd0_m;
    logic       last_wr_ok;

    always #5 clk = ~clk;

    sync_fifo #(
        .DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst(rst), .wdata(wdata), .write(write),
        .full(full1), .almost_full(afull1), .read(read),
        .rdata(rdata1), .empty(empty1), .almost_empty(aempty1),
        .count(count1), .err_clr(err_clr),
        .overflow(ovf1), .underflow(unf1)
    );

    sync_fifo #(
        .DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)
    ) u_reg (
        .clk(clk), .rst(rst), .wdata(wdata), .write(write),
        .full(full0), .almost_full(afull0), .read(read),
        .rdata(rdata0), .empty(empty0), .almost_empty(aempty0),
        .count(count0), .err_clr(err_clr),
        .overflow(ovf0), .underflow(unf0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = q.size();
        chk("count",     32'(count1),  32'(n));
        chk("empty",     32'(empty1),  32'(n == 0));
        chk("full",      32'(full1),   32'(n == 16));
        chk("afull",     32'(afull1),  32'(n >= 14));
        chk("aempty",    32'(aempty1), 32'(n <= 2));
        chk("overflow",  32'(ovf1),    32'(ovf_m));
        chk("underflow", 32'(unf1),    32'(unf_m));
        if (n > 0) chk("rdata_fwft", 32'(rdata1), 32'(q[0]));
        chk("count_reg", 32'(count0),  32'(n));
        chk("full_reg",  32'(full0),   32'(n == 16));
        chk("rdata_reg", 32'(rdata0),  32'(rd0_m));
    endtask

    task automatic rst_cycle();
        rst = 1'b1; write = 1'b0; read = 1'b0; err_clr = 1'b0;
        wdata = 8'h00;
        @(posedge clk);
        q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        rd0_m = 8'h00;
        #1;
        rst = 1'b0;
    endtask

    task automatic step(input logic w, input logic [7:0] d,
                        input logic r, input logic clr);
        logic rok, wok;
        check_outputs();
        write = w; wdata = d; read = r; err_clr = clr;
        @(posedge clk);
        rok = r && (q.size() > 0);
        wok = w && ((q.size() < 16) || rok);
        ovf_m = (ovf_m && !clr) || (w && !wok);
        unf_m = (unf_m && !clr) || (r && (q.size() == 0));
        if (rok) rd0_m = q.pop_front();
        if (wok) q.push_back(d);
        last_wr_ok = wok;
        #1;
        write = 1'b0; read = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int written;
        int k;
        rst_cycle();
        rst_cycle();
        chk("reset_rdata_reg", 32'(rdata0), 32'h0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full1), 32'h1);
        chk("fill_count", 32'(count1), 32'd16);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf1), 32'h1);

        for (int i = 0; i < 16; i++) begin
            chk("drain_fwft", 32'(rdata1), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_reg", 32'(rdata0), 32'(i));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", 32'(unf0), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("rw_full_count", 32'(count1), 32'd16);
        chk("rw_full_ovf", 32'(ovf1), 32'h0);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rw_full_55", 32'(rdata1), 32'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rw_full_55_reg", 32'(rdata0), 32'h55);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        written = 0;
        k = 0;
        while (k < 1000 && (written < 40 || q.size() > 0)) begin
            step((written < 40) && ($urandom_range(0, 2) != 0),
                 8'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7) == 0);
            if (last_wr_ok) written++;
            k++;
        end
        chk("stream_done", 32'(written == 40 && q.size() == 0), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count1), 32'd9);
        rst_cycle();
        chk("rst_count", 32'(count1), 32'd0);
        chk("rst_empty", 32'(empty1), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        chk("after_rst_77", 32'(rdata1), 32'h77);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("after_rst_77_reg", 32'(rdata0), 32'h77);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
